// File: rtl/axis_packet_generator.sv
// axis_packet_generator
//   AXI4-Stream packet source for bring-up and throughput testing.
//   Emits packets of (beats_per_packet+1) beats with an optional partial
//   last beat, an optional idle gap between packets, a finite or continuous
//   packet count and two data patterns. Configuration is captured on start.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   start, stop        one-cycle control pulses
//   beats_per_packet   index of last beat in a packet
//   last_bytes         valid bytes in last beat (0 or > DATA_W/8 = full)
//   num_packets        packets to send (0 = continuous)
//   gap_cycles         idle cycles between packets
//   pattern_sel        0 = replicated counter, 1 = lane-incrementing
//   busy, done         status: not idle / end-of-generation pulse
//   beat, packet_count current beat index / packets completed
//   axisout_*          AXI4-Stream master interface
module axis_packet_generator #(
  parameter int DATA_W  = 256,
  parameter int VALUE_W = 16,
  parameter int BEAT_W  = 4,
  parameter int CNT_W   = 16,
  parameter int GAP_W   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stop,
  input  logic [BEAT_W-1:0]         beats_per_packet,
  input  logic [$clog2(DATA_W/8):0] last_bytes,
  input  logic [CNT_W-1:0]          num_packets,
  input  logic [GAP_W-1:0]          gap_cycles,
  input  logic                      pattern_sel,
  output logic                      busy,
  output logic                      done,
  output logic [BEAT_W-1:0]         beat,
  output logic [CNT_W-1:0]          packet_count,
  output logic [DATA_W-1:0]         axisout_tdata,
  output logic                      axisout_tvalid,
  output logic                      axisout_tlast,
  output logic [DATA_W/8-1:0]       axisout_tkeep,
  input  logic                      axisout_tready
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int LANES  = DATA_W / VALUE_W;
  localparam int LB_W   = $clog2(KEEP_W) + 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t             state_q, state_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               stop_pend_q, stop_pend_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [VALUE_W-1:0] value_q, value_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [BEAT_W-1:0]  bpp_q, bpp_d;
  logic [LB_W-1:0]    lb_q, lb_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               pat_q, pat_d;

  logic               accept;
  logic               last_beat;
  logic [CNT_W-1:0]   pkt_next;
  logic               stop_now;

  assign accept    = valid_q & axisout_tready;
  assign last_beat = (beat_q == bpp_q);
  assign pkt_next  = pkt_cnt_q + CNT_W'(1);
  // A stop arriving in the same cycle as the decision counts as pending.
  assign stop_now  = stop_pend_q | stop;

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    stop_pend_d = stop_pend_q;
    beat_d      = beat_q;
    pkt_cnt_d   = pkt_cnt_q;
    value_d     = value_q;
    gap_cnt_d   = gap_cnt_q;
    bpp_d       = bpp_q;
    lb_d        = lb_q;
    num_d       = num_q;
    gap_d       = gap_q;
    pat_d       = pat_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bpp_d       = beats_per_packet;
          lb_d        = last_bytes;
          num_d       = num_packets;
          gap_d       = gap_cycles;
          pat_d       = pattern_sel;
          pkt_cnt_d   = '0;
          value_d     = '0;
          beat_d      = '0;
          stop_pend_d = 1'b0;
          valid_d     = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (stop) stop_pend_d = 1'b1;
        if (accept) begin
          value_d = value_q + VALUE_W'(1);
          if (!last_beat) begin
            beat_d = beat_q + BEAT_W'(1);
          end else begin
            beat_d    = '0;
            pkt_cnt_d = pkt_next;
            if (stop_now || (num_q != '0 && pkt_next == num_q)) begin
              valid_d     = 1'b0;
              done_d      = 1'b1;
              stop_pend_d = 1'b0;
              state_d     = IDLE;
            end else if (gap_q != '0) begin
              // Counter runs gap_q-1 .. 0, giving exactly gap_q idle cycles.
              valid_d   = 1'b0;
              gap_cnt_d = gap_q - GAP_W'(1);
              state_d   = GAP;
            end
          end
        end
      end
      GAP: begin
        if (stop) stop_pend_d = 1'b1;
        if (gap_cnt_q == '0) begin
          if (stop_now) begin
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
            state_d     = IDLE;
          end else begin
            valid_d = 1'b1;
            state_d = SEND;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      beat_q      <= '0;
      pkt_cnt_q   <= '0;
      value_q     <= '0;
      gap_cnt_q   <= '0;
      bpp_q       <= '0;
      lb_q        <= '0;
      num_q       <= '0;
      gap_q       <= '0;
      pat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      stop_pend_q <= stop_pend_d;
      beat_q      <= beat_d;
      pkt_cnt_q   <= pkt_cnt_d;
      value_q     <= value_d;
      gap_cnt_q   <= gap_cnt_d;
      bpp_q       <= bpp_d;
      lb_q        <= lb_d;
      num_q       <= num_d;
      gap_q       <= gap_d;
      pat_q       <= pat_d;
    end
  end

  always_comb begin
    axisout_tdata = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      axisout_tdata[i*VALUE_W +: VALUE_W] = pat_q ? value_q + VALUE_W'(i) : value_q;
    end
  end

  always_comb begin
    axisout_tkeep = '1;
    if (last_beat && lb_q != '0 && lb_q <= LB_W'(KEEP_W)) begin
      for (int unsigned i = 0; i < KEEP_W; i++) begin
        axisout_tkeep[i] = (LB_W'(i) < lb_q);
      end
    end
  end

  assign axisout_tvalid = valid_q;
  assign axisout_tlast  = last_beat;
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign beat           = beat_q;
  assign packet_count   = pkt_cnt_q;

endmodule

// File: tb/tb_axis_packet_generator.sv
// Self-checking bench for axis_packet_generator with a beat-sequence model:
// global accepted-beat index k gives value = k mod 2^16, beat = k mod (bpp+1).
module tb_axis_packet_generator;
  logic         clk = 1'b0;
  logic         reset, start, stop, pattern_sel;
  logic [3:0]   beats_per_packet;
  logic [5:0]   last_bytes;
  logic [15:0]  num_packets;
  logic [7:0]   gap_cycles;
  logic         busy, done;
  logic [3:0]   beat;
  logic [15:0]  packet_count;
  logic [255:0] tdata;
  logic         tvalid, tlast, tready;
  logic [31:0]  tkeep;

  int checks = 0;
  int passed = 0;
  int m_bpp, m_lb;
  bit m_pat;

  axis_packet_generator #(.DATA_W(256), .VALUE_W(16), .BEAT_W(4), .CNT_W(16), .GAP_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .beats_per_packet(beats_per_packet), .last_bytes(last_bytes),
    .num_packets(num_packets), .gap_cycles(gap_cycles), .pattern_sel(pattern_sel),
    .busy(busy), .done(done), .beat(beat), .packet_count(packet_count),
    .axisout_tdata(tdata), .axisout_tvalid(tvalid), .axisout_tlast(tlast),
    .axisout_tkeep(tkeep), .axisout_tready(tready)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] model_data(input int unsigned k, input bit pat);
    logic [255:0] d;
    logic [15:0]  v;
    v = 16'(k);
    for (int i = 0; i < 16; i++) d[i*16 +: 16] = pat ? 16'(v + i) : v;
    return d;
  endfunction

  function automatic logic [31:0] model_keep(input bit last, input int lb);
    logic [63:0] m;
    if (!last || lb == 0 || lb > 32) return '1;
    m = (64'd1 << lb) - 64'd1;
    return m[31:0];
  endfunction

  task automatic do_start(input int bpp, input int lb, input int num, input int gap, input bit pat);
    @(negedge clk);
    beats_per_packet = 4'(bpp);
    last_bytes       = 6'(lb);
    num_packets      = 16'(num);
    gap_cycles       = 8'(gap);
    pattern_sel      = pat;
    start            = 1'b1;
    m_bpp = bpp; m_lb = lb; m_pat = pat;
    @(negedge clk);
    start = 1'b0;
    // Configuration must be ignored once latched.
    beats_per_packet = 4'($urandom);
    last_bytes       = 6'($urandom);
    num_packets      = 16'($urandom);
    gap_cycles       = 8'($urandom);
    pattern_sel      = 1'($urandom);
  endtask

  task automatic test_reset();
    checks++; if ({tvalid, busy, done} !== 3'b000) $display("FAIL reset_ctrl got valid/busy/done=%b exp 000", {tvalid, busy, done}); else passed++;
    checks++; if ({beat, packet_count} !== 20'd0) $display("FAIL reset_counts got beat=%0d pc=%0d exp 0 0", beat, packet_count); else passed++;
    checks++; if (tdata !== 256'd0 || tlast !== 1'b1 || tkeep !== 32'hFFFFFFFF)
      $display("FAIL reset_data got data=%h last=%b keep=%h exp 0 1 ffffffff", tdata, tlast, tkeep); else passed++;
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({tvalid, busy, done} !== 3'b000) $display("FAIL reset_idle got valid/busy/done=%b exp 000", {tvalid, busy, done}); else passed++;
  endtask

  task automatic test_basic();
    int k = 0, dones = 0, lows = 0;
    int unsigned idx;
    bit lastx;
    do_start(3, 2, 2, 0, 0);
    tready = 1'b1;
    for (int c = 0; c < 40 && dones == 0; c++) begin
      start = (c == 3); // ignored while busy
      if (tvalid) begin
        idx = k % (m_bpp + 1); lastx = (idx == m_bpp);
        checks++;
        if (tdata !== model_data(k, m_pat) || tlast !== lastx || tkeep !== model_keep(lastx, m_lb) || beat !== 4'(idx))
          $display("FAIL basic_beat k=%0d got data=%h last=%b keep=%h beat=%0d exp data=%h last=%b keep=%h beat=%0d",
                   k, tdata, tlast, tkeep, beat, model_data(k, m_pat), lastx, model_keep(lastx, m_lb), idx);
        else passed++;
        k++;
      end else if (busy) lows++;
      @(negedge clk);
      if (done) dones++;
    end
    start = 1'b0;
    repeat (3) begin @(negedge clk); if (done) dones++; end
    checks++; if (k != 8) $display("FAIL basic_beats got %0d exp 8", k); else passed++;
    checks++; if (lows != 0) $display("FAIL basic_b2b got %0d idle cycles exp 0", lows); else passed++;
    checks++; if (dones != 1) $display("FAIL basic_done got %0d pulses exp 1", dones); else passed++;
    checks++; if (packet_count !== 16'd2 || busy !== 1'b0) $display("FAIL basic_end got pc=%0d busy=%b exp 2 0", packet_count, busy); else passed++;
  endtask

  task automatic test_stall(input bit rnd);
    int k = 0, dones = 0, bpp, lb, num;
    bit pat, hold = 0, expv = 0, lastx;
    logic [293:0] snap;
    logic [3:0] rp = 4'b1001;
    int unsigned idx;
    if (rnd) begin
      bpp = $urandom_range(0, 5); lb = $urandom_range(0, 40); num = $urandom_range(1, 3); pat = 1'($urandom);
    end else begin
      bpp = 3; lb = 2; num = 2; pat = 0;
    end
    do_start(bpp, lb, num, 0, pat);
    for (int c = 0; c < 400 && dones == 0; c++) begin
      tready = rnd ? 1'($urandom) : rp[c % 4];
      if (hold) begin
        checks++;
        if ({tvalid, tlast, beat, tkeep, tdata} !== snap) $display("FAIL stall_hold got %h exp %h", {tvalid, tlast, beat, tkeep, tdata}, snap);
        else passed++;
      end
      if (expv) begin
        checks++; if (tvalid !== 1'b1) $display("FAIL tvalid_drop got %b exp 1", tvalid); else passed++;
      end
      hold = 0; expv = 0;
      if (tvalid && tready) begin
        idx = k % (bpp + 1); lastx = (idx == bpp);
        checks++;
        if (tdata !== model_data(k, pat) || tlast !== lastx || tkeep !== model_keep(lastx, lb) || beat !== 4'(idx))
          $display("FAIL stall_beat k=%0d got data=%h last=%b keep=%h beat=%0d exp data=%h last=%b keep=%h beat=%0d",
                   k, tdata, tlast, tkeep, beat, model_data(k, pat), lastx, model_keep(lastx, lb), idx);
        else passed++;
        expv = !lastx;
        k++;
      end else if (tvalid) begin
        hold = 1; snap = {tvalid, tlast, beat, tkeep, tdata};
      end
      @(negedge clk);
      if (done) dones++;
    end
    tready = 1'b1;
    checks++; if (k != num * (bpp + 1)) $display("FAIL stall_beats got %0d exp %0d", k, num * (bpp + 1)); else passed++;
    checks++; if (dones != 1 || packet_count !== 16'(num)) $display("FAIL stall_end got done=%0d pc=%0d exp 1 %0d", dones, packet_count, num); else passed++;
  endtask

  task automatic test_gap();
    int k = 0, dones = 0, run = 0, gaps = 0;
    int unsigned idx;
    do_start(1, 0, 3, 3, 0);
    tready = 1'b1;
    for (int c = 0; c < 60 && dones == 0; c++) begin
      if (tvalid) begin
        if (run > 0) begin
          gaps++;
          checks++; if (run != 3) $display("FAIL gap_len got %0d exp 3", run); else passed++;
          run = 0;
        end
        idx = k % 2;
        checks++;
        if (tdata !== model_data(k, 0) || beat !== 4'(idx)) $display("FAIL gap_beat k=%0d got data=%h beat=%0d exp data=%h beat=%0d", k, tdata, beat, model_data(k, 0), idx);
        else passed++;
        k++;
      end else if (busy) run++;
      @(negedge clk);
      if (done) dones++;
    end
    checks++; if (k != 6 || gaps != 2) $display("FAIL gap_total got beats=%0d gaps=%0d exp 6 2", k, gaps); else passed++;
    checks++; if (dones != 1 || packet_count !== 16'd3) $display("FAIL gap_end got done=%0d pc=%0d exp 1 3", dones, packet_count); else passed++;
  endtask

  task automatic test_stop();
    int k = 0, dones = 0;
    bit sent = 0;
    int unsigned idx;
    do_start(3, 0, 0, 0, 1);
    for (int c = 0; c < 200 && dones == 0; c++) begin
      stop = 1'b0;
      tready = 1'($urandom);
      if (tvalid && k == 17 && !sent) begin stop = 1'b1; sent = 1; end
      if (tvalid && tready) begin
        idx = k % 4;
        checks++;
        if (tdata !== model_data(k, 1) || beat !== 4'(idx)) $display("FAIL stop_beat k=%0d got data=%h beat=%0d exp data=%h beat=%0d", k, tdata, beat, model_data(k, 1), idx);
        else passed++;
        k++;
      end
      @(negedge clk);
      if (done) begin
        dones++;
        checks++; if (tvalid !== 1'b0) $display("FAIL stop_valid got %b exp 0", tvalid); else passed++;
      end
    end
    stop = 1'b0; tready = 1'b1;
    checks++; if (k != 20) $display("FAIL stop_beats got %0d exp 20", k); else passed++;
    checks++; if (dones != 1 || packet_count !== 16'd5) $display("FAIL stop_end got done=%0d pc=%0d exp 1 5", dones, packet_count); else passed++;
  endtask

  task automatic test_stop_gap();
    int k = 0, dones = 0;
    bit sent = 0;
    do_start(0, 5, 0, 4, 0);
    tready = 1'b1;
    for (int c = 0; c < 60 && dones == 0; c++) begin
      stop = 1'b0;
      if (!tvalid && busy && k == 2 && !sent) begin stop = 1'b1; sent = 1; end
      if (tvalid) begin
        checks++;
        if (tlast !== 1'b1 || tkeep !== 32'h0000001F) $display("FAIL single_beat got last=%b keep=%h exp 1 0000001f", tlast, tkeep); else passed++;
        k++;
      end
      @(negedge clk);
      if (done) dones++;
    end
    stop = 1'b0;
    checks++; if (k != 2 || dones != 1 || packet_count !== 16'd2)
      $display("FAIL stop_gap got beats=%0d done=%0d pc=%0d exp 2 1 2", k, dones, packet_count); else passed++;
  endtask

  task automatic test_pattern_wrap();
    int k = 0, dones = 0;
    logic [255:0] d;
    do_start(15, 0, 0, 0, 1);
    tready = 1'b1;
    for (int c = 0; c < 70000 && dones == 0; c++) begin
      stop = 1'b0;
      if (tvalid) begin
        d = tdata;
        if (k == 32'hFFF8) stop = 1'b1;
        if (k == 32'hFFFE) begin
          checks++; if (d !== model_data(k, 1)) $display("FAIL wrap_lanes got %h exp %h", d, model_data(k, 1)); else passed++;
          checks++; if (d[15:0] !== 16'hFFFE || d[47:32] !== 16'h0000 || d[255:240] !== 16'h000D)
            $display("FAIL wrap_edges got l0=%h l2=%h l15=%h exp fffe 0000 000d", d[15:0], d[47:32], d[255:240]); else passed++;
        end
        if (k == 32'hFFFF) begin
          checks++; if (d[15:0] !== 16'hFFFF) $display("FAIL wrap_next got %h exp ffff", d[15:0]); else passed++;
        end
        k++;
      end
      @(negedge clk);
      if (done) dones++;
    end
    stop = 1'b0;
    checks++; if (dones != 1 || k != 65536 || packet_count !== 16'd4096)
      $display("FAIL wrap_end got done=%0d beats=%0d pc=%0d exp 1 65536 4096", dones, k, packet_count); else passed++;
  endtask

  task automatic test_reset_mid();
    int k = 0, dones = 0;
    do_start(7, 3, 0, 0, 1);
    tready = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if ({tvalid, busy, done, beat, packet_count} !== 23'd0)
      $display("FAIL rst_async got valid=%b busy=%b done=%b beat=%0d pc=%0d exp all 0", tvalid, busy, done, beat, packet_count); else passed++;
    checks++; if (tdata !== 256'd0 || tlast !== 1'b1 || tkeep !== 32'hFFFFFFFF)
      $display("FAIL rst_async_data got data=%h last=%b keep=%h exp 0 1 ffffffff", tdata, tlast, tkeep); else passed++;
    @(negedge clk);
    checks++; if (done !== 1'b0) $display("FAIL rst_nodone got %b exp 0", done); else passed++;
    reset = 1'b0;
    do_start(2, 1, 1, 0, 0);
    checks++; if (tvalid !== 1'b1 || tdata !== 256'd0 || beat !== 4'd0)
      $display("FAIL rst_restart got valid=%b data=%h beat=%0d exp 1 0 0", tvalid, tdata, beat); else passed++;
    for (int c = 0; c < 30 && dones == 0; c++) begin
      if (tvalid) begin
        checks++;
        if (tdata !== model_data(k, 0) || tkeep !== model_keep(k == 2, 1))
          $display("FAIL rst_beat k=%0d got data=%h keep=%h exp data=%h keep=%h", k, tdata, tkeep, model_data(k, 0), model_keep(k == 2, 1));
        else passed++;
        k++;
      end
      @(negedge clk);
      if (done) dones++;
    end
    checks++; if (k != 3 || dones != 1) $display("FAIL rst_end got beats=%0d done=%0d exp 3 1", k, dones); else passed++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; tready = 1'b0; pattern_sel = 1'b0;
    beats_per_packet = '0; last_bytes = '0; num_packets = '0; gap_cycles = '0;
    #12;
    test_reset();
    test_basic();
    test_stall(1'b0);
    for (int r = 0; r < 4; r++) test_stall(1'b1);
    test_gap();
    test_stop();
    test_stop_gap();
    test_reset_mid();
    test_pattern_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
